// File: rtl/smvm_streamer.sv
// smvm_streamer: buffers a dense vector and sparse nonzero list, then streams them in SMVM input format.
module smvm_streamer #(
  parameter int K         = 4,
  parameter int VEC_DEPTH = 128,
  parameter int NNZ_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_rows,
  input  logic [7:0] cfg_cols,
  input  logic       wr_en,
  input  logic       wr_vec,
  input  logic [7:0] wr_val,
  input  logic [6:0] wr_col,
  input  logic       wr_last,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ovf,
  output logic [7:0] val_out,
  output logic [2:0] col_out,
  output logic       ipv_out,
  output logic       out_valid
);
  localparam int VA = $clog2(VEC_DEPTH);
  localparam int NA = $clog2(NNZ_DEPTH);
  localparam logic [7:0] VD = 8'(VEC_DEPTH);
  localparam logic [7:0] ND = 8'(NNZ_DEPTH);
  localparam logic [7:0] KK = 8'(K);

  typedef enum logic [2:0] {IDLE, HDR_ROW, HDR_COL, VEC, NZ_VAL, NZ_IDX, FIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  vec_q [VEC_DEPTH];
  logic [7:0]  vec_d [VEC_DEPTH];
  logic [15:0] nnz_q [NNZ_DEPTH];
  logic [15:0] nnz_d [NNZ_DEPTH];
  logic [7:0]  vec_cnt_q, vec_cnt_d, nnz_cnt_q, nnz_cnt_d, idx_q, idx_d;
  logic [7:0]  rows_q, rows_d, cols_q, cols_d, pairs_q, pairs_d;
  logic        ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        valid_q, valid_d, ipv_q, ipv_d;
  logic [7:0]  val_q, val_d;
  logic [2:0]  col_q, col_d;
  logic        idle, accept, we, vfull, nfull;
  logic [7:0]  vv;
  logic [15:0] ent;
  logic [11:0] w;

  always_comb begin
    idle      = state_q == IDLE;
    accept    = idle && start && cfg_cols != 8'd0 && cfg_cols <= VD && nnz_cnt_q != 8'd0;
    we        = idle && wr_en && !accept;
    vfull     = vec_cnt_q == VD;
    nfull     = nnz_cnt_q == ND;
    vec_d     = vec_q;
    nnz_d     = nnz_q;
    vec_cnt_d = vec_cnt_q;
    nnz_cnt_d = nnz_cnt_q;
    ovf_d     = accept ? 1'b0 : ovf_q | (we && (wr_vec ? vfull : nfull));
    state_d   = state_q;
    idx_d     = idx_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    pairs_d   = pairs_q;
    if (we && wr_vec && !vfull) begin
      vec_d[vec_cnt_q[VA-1:0]] = wr_val;
      vec_cnt_d = vec_cnt_q + 8'd1;
    end
    if (we && !wr_vec && !nfull) begin
      nnz_d[nnz_cnt_q[NA-1:0]] = {wr_val, wr_col, wr_last};
      nnz_cnt_d = nnz_cnt_q + 8'd1;
    end
    case (state_q)
      IDLE: if (accept) begin
        state_d = HDR_ROW;
        idx_d   = 8'd0;
        rows_d  = cfg_rows;
        cols_d  = cfg_cols;
        pairs_d = ((nnz_cnt_q + KK - 8'd1) / KK) * KK;
      end
      HDR_ROW: state_d = HDR_COL;
      HDR_COL: state_d = VEC;
      VEC: begin
        state_d = idx_q == cols_q - 8'd1 ? NZ_VAL : VEC;
        idx_d   = idx_q == cols_q - 8'd1 ? 8'd0 : idx_q + 8'd1;
      end
      NZ_VAL: state_d = NZ_IDX;
      NZ_IDX: begin
        state_d = idx_q == pairs_q - 8'd1 ? FIN : NZ_VAL;
        idx_d   = idx_q + 8'd1;
      end
      FIN: begin
        state_d   = IDLE;
        vec_cnt_d = 8'd0;
        nnz_cnt_d = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output beat is derived from the current state and registered, so it trails the state by one cycle.
  always_comb begin
    vv      = idx_q < vec_cnt_q ? vec_q[idx_q[VA-1:0]] : 8'd0;
    ent     = idx_q < nnz_cnt_q ? nnz_q[idx_q[NA-1:0]] : 16'd0;
    w       = state_q == HDR_ROW ? {4'b0, rows_q} :
              state_q == HDR_COL ? {4'b0, cols_q} :
              state_q == NZ_IDX  ? {5'b0, ent[7:1]} : 12'd0;
    val_d   = state_q == VEC ? vv : state_q == NZ_VAL ? ent[15:8] : w[11:4];
    ipv_d   = state_q == NZ_VAL ? ent[0] : w[3];
    col_d   = w[2:0];
    valid_d = !idle && state_q != FIN;
    busy_d  = accept || valid_d;
    done_d  = state_q == FIN;
    err_d   = idle && start && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_DEPTH; i++) vec_q[i] <= '0;
      for (int i = 0; i < NNZ_DEPTH; i++) nnz_q[i] <= '0;
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      nnz_cnt_q <= '0;
      idx_q     <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      pairs_q   <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ipv_q     <= 1'b0;
      val_q     <= '0;
      col_q     <= '0;
    end else begin
      vec_q     <= vec_d;
      nnz_q     <= nnz_d;
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      nnz_cnt_q <= nnz_cnt_d;
      idx_q     <= idx_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      pairs_q   <= pairs_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ipv_q     <= ipv_d;
      val_q     <= val_d;
      col_q     <= col_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign val_out   = val_q;
  assign col_out   = col_q;
  assign ipv_out   = ipv_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_smvm_streamer.sv
// tb_smvm_streamer: random and directed loads checked against a queue-based stream model.
module tb_smvm_streamer;
  localparam int K = 4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] cfg_rows = '0, cfg_cols = '0, wr_val = '0;
  logic [6:0] wr_col = '0;
  logic       wr_en = 1'b0, wr_vec = 1'b0, wr_last = 1'b0, start = 1'b0;
  logic       busy, done, err, ovf, ipv_out, out_valid;
  logic [7:0] val_out;
  logic [2:0] col_out;
  int total = 0, bad = 0;
  logic [7:0] mvec [128];
  logic [7:0] mval [64];
  logic [6:0] mcol [64];
  logic       mlast [64];
  int  vcnt = 0, ncnt = 0;
  bit  movf = 0;

  smvm_streamer #(.K(K), .VEC_DEPTH(128), .NNZ_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .wr_en(wr_en), .wr_vec(wr_vec), .wr_val(wr_val), .wr_col(wr_col), .wr_last(wr_last),
    .start(start), .busy(busy), .done(done), .err(err), .ovf(ovf),
    .val_out(val_out), .col_out(col_out), .ipv_out(ipv_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit v, input logic [7:0] d, input logic [6:0] c, input bit l);
    wr_en = 1'b1; wr_vec = v; wr_val = d; wr_col = c; wr_last = l;
    @(negedge clk);
    wr_en = 1'b0;
    if (v) begin
      if (vcnt < 128) begin mvec[vcnt] = d; vcnt++; end else movf = 1;
    end else begin
      if (ncnt < 64) begin mval[ncnt] = d; mcol[ncnt] = c; mlast[ncnt] = l; ncnt++; end else movf = 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mvec[i] = '0;
    for (int i = 0; i < 64; i++) begin mval[i] = '0; mcol[i] = '0; mlast[i] = 0; end
    vcnt = 0; ncnt = 0; movf = 0;
  endtask

  task automatic run(input int rows, input int cols, input bit wr_same);
    bit ok;
    int p;
    logic [11:0] exp[$];
    ok = cols >= 1 && cols <= 128 && ncnt > 0;
    check("ovf_pre", 32'(ovf), 32'(movf));
    start = 1'b1; cfg_rows = 8'(rows); cfg_cols = 8'(cols);
    if (wr_same && ok) begin wr_en = 1'b1; wr_vec = 1'b0; wr_val = 8'h5A; wr_col = 7'h11; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (!ok) begin
      check("err_pulse", 32'(err), 32'd1);
      check("rej_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("err_clr", 32'(err), 32'd0);
      check("rej_busy", 32'(busy), 32'd0);
      return;
    end
    movf = 0;
    check("busy_start", 32'(busy), 32'd1);
    check("ovf_clr", 32'(ovf), 32'd0);
    check("pre_valid", 32'(out_valid), 32'd0);
    exp.push_back({4'b0, 8'(rows)});
    exp.push_back({4'b0, 8'(cols)});
    for (int i = 0; i < cols; i++) exp.push_back({(i < vcnt) ? mvec[i] : 8'd0, 4'b0});
    p = ((ncnt + K - 1) / K) * K;
    for (int i = 0; i < p; i++) begin
      exp.push_back(i < ncnt ? {mval[i], mlast[i], 3'b0} : 12'd0);
      exp.push_back(i < ncnt ? {5'b0, mcol[i]} : 12'd0);
    end
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge clk);
      check("beat", 32'({out_valid, val_out, ipv_out, col_out}), 32'({1'b1, exp[i]}));
      if (i == exp.size() / 2) check("busy_mid", 32'(busy), 32'd1);
      wr_en = (i < exp.size() - 1) ? 1'($urandom % 2) : 1'b0;
      wr_vec = 1'($urandom % 2); wr_val = 8'($urandom);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    vcnt = 0; ncnt = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_out", 32'({busy, done, err, ovf, val_out, col_out, ipv_out, out_valid}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) wr(1, 8'(i), 7'd0, 0);
    wr(0, 8'd5, 7'd0, 1); wr(0, 8'hFD, 7'd2, 0); wr(0, 8'd7, 7'd3, 1); wr(0, 8'd2, 7'd1, 0);
    run(2, 4, 0);
    for (int i = 0; i < 3; i++) wr(1, 8'($urandom), 7'd0, 0);
    wr(0, 8'd9, 7'd100, 1);
    for (int i = 0; i < 4; i++) wr(0, 8'($urandom), 7'($urandom), 1'($urandom));
    run(7, 3, 1);
    run(1, 4, 0);
    wr(0, 8'd1, 7'd1, 1);
    run(1, 0, 0);
    run(1, 129, 0);
    run(200, 2, 0);
    for (int i = 0; i < 129; i++) wr(1, 8'($urandom), 7'd0, 0);
    for (int i = 0; i < 65; i++) wr(0, 8'($urandom), 7'($urandom), 1'($urandom));
    check("ovf_set", 32'(ovf), 32'd1);
    run(64, 128, 0);
    for (int it = 0; it < 8; it++) begin
      int nv, nn;
      nv = $urandom_range(0, 10); nn = $urandom_range(1, 12);
      while (nv + nn > 0) begin
        if (nn == 0 || (nv > 0 && $urandom % 2 == 1)) begin wr(1, 8'($urandom), 7'd0, 0); nv--; end
        else begin wr(0, 8'($urandom), 7'($urandom), 1'($urandom)); nn--; end
      end
      run($urandom_range(0, 255), $urandom_range(1, 16), 1'($urandom % 2));
    end
    wr(1, 8'd11, 7'd0, 0); wr(0, 8'd3, 7'd5, 1);
    start = 1'b1; cfg_rows = 8'd1; cfg_cols = 8'd8;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'({busy, done, out_valid, val_out, col_out, ipv_out}), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    wr(1, 8'd21, 7'd0, 0); wr(1, 8'd22, 7'd0, 0);
    wr(0, 8'hF0, 7'd9, 1);
    run(1, 4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/smvm_streamer.md
Name: smvm_streamer

Overview:
- Transmit-side companion to the SMVM accelerator. The host loads the dense vector and the sparse nonzero list into local buffers; on start, the block drives the SMVM input protocol on val_out/col_out/ipv_out/out_valid.
- It is used as the front end feeding SMVM in the integration testbench and in the top-level wrapper.
- It pads the nonzero stream to a multiple of K so the receiver's K-wide ALU batches always fill.

Parameters:
- K, 4, nonzeros per ALU batch; the stream is padded to a multiple of K.
- VEC_DEPTH, 128, vector buffer entries.
- NNZ_DEPTH, 64, nonzero buffer entries.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_rows  in  8  matrix row count; sampled at start.
- cfg_cols  in  8  vector length, 1..VEC_DEPTH; sampled at start.
- wr_en  in  1  load strobe; ignored while busy.
- wr_vec  in  1  1 = vector entry, 0 = nonzero entry.
- wr_val  in  8  signed value; vector element or matrix value.
- wr_col  in  7  column index; nonzero entries only.
- wr_last  in  1  nonzero entry is the last one of its row.
- start  in  1  single-cycle pulse that begins the stream.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the stream ends.
- err  out  1  one-cycle pulse when start is rejected.
- ovf  out  1  sticky flag: a write was dropped because its buffer was full. Cleared by an accepted start.
- val_out  out  8  stream value field.
- col_out  out  3  stream column field.
- ipv_out  out  1  stream ipv field.
- out_valid  out  1  stream beat valid.

Behaviour:
- Reset: all outputs 0; state IDLE; vec_cnt=0, nnz_cnt=0; buffers 0.
- All stream outputs are registered.
- Header word encoding: 12-bit word W maps to val_out=W[11:4], ipv_out=W[3], col_out=W[2:0].
- Load phase (IDLE only):
  - wr_en with wr_vec=1 stores wr_val at vec[vec_cnt], then increments vec_cnt.
  - wr_en with wr_vec=0 stores {wr_val, wr_col, wr_last} at nnz[nnz_cnt], then increments nnz_cnt.
  - A write to a full buffer is dropped and sets ovf.
- Start acceptance (IDLE): start is accepted when cfg_cols is 1..VEC_DEPTH and nnz_cnt>0.
  - Otherwise err pulses the next cycle and the block stays IDLE.
  - start while busy is ignored.
- States and transitions, one out_valid=1 beat per state cycle:
  - HDR_ROW: W={4'b0, rows}.
  - HDR_COL: W={4'b0, cols}.
  - VEC: cols beats. val_out=vec[i] for i<vec_cnt, otherwise 0. ipv_out=0, col_out=0.
  - NZ_VAL: val_out=matrix value, ipv_out=wr_last flag of that entry, col_out=0.
  - NZ_IDX: W={5'b0, col}.
  - NZ_VAL/NZ_IDX alternate for each stored entry, then for pad entries (value 0, ipv 0, column 0).
  - Total nonzero pairs P = ceil(nnz_cnt/K)*K.
  - FIN: out_valid=0, done=1, busy drops; vec_cnt and nnz_cnt clear to 0, then IDLE.
- Latency: start accepted at edge t gives the first beat (HDR_ROW) valid after edge t+1. The stream is contiguous: 2 + cols + 2P beats with no bubbles, followed by at least one idle cycle (FIN).
- Rows with no nonzeros are not encoded; the host is responsible for them.
- Index counters are 8 bits and wrap is unreachable given the depth limits.
- Asynchronous reset mid-stream: out_valid drops immediately, all state clears, and the stream is abandoned with no done.
- A wr_en in the same cycle as an accepted start is dropped and does not set ovf.

Test Plan:
- Load vec {1,2,3,4}, nnz {(5,c0,last),(-3,c2,0),(7,c3,last),(2,c1,0)}, rows=2, cols=4, start. Required beats: hdr 2, hdr 4, 1,2,3,4, then pairs (5/ipv1, 0), (-3/0, 2), (7/1, 3), (2/0, 1). done 1 cycle after the last beat, 14 beats total.
- 5 nonzeros with K=4: P=8, so 3 pad pairs of all-zero fields follow. Stream length 2+cols+16.
- Column index 100 (0x64): NZ_IDX beat shows val_out=0x06, ipv_out=0, col_out=3'b100.
- start with cfg_cols=0, or with nnz_cnt=0: err pulses once, out_valid stays 0, state stays IDLE.
- Write 65 nonzeros: ovf=1, 65th entry dropped, stream carries 64 pairs. ovf clears on the next accepted start.
- Assert rst_n low during VEC: outputs 0 asynchronously. After release a fresh load plus start streams correctly from HDR_ROW. vec_cnt=2 with cols=4 streams 2 values then two 0 beats.
